// File: rtl/interrupt_controller_n.sv
// Parametrised interrupt controller: NUM_GPIO maskable GPIO sources (edge or
// level), one always-edge external pin and one auto-reload timer, arbitrated
// at fixed priority onto a request/ack handshake with the control unit.
// Source/pending bit order: 0 = external pin, 1 = timer, 2+i = GPIO i.
module interrupt_controller_n #(
  parameter  int NUM_GPIO    = 8,
  parameter  int TIMER_WIDTH = 32,
  parameter  int SYNC_STAGES = 2,
  localparam int SRC_W       = $clog2(NUM_GPIO + 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_GPIO-1:0]    gpio_interrupt_pins,
  input  logic [NUM_GPIO-1:0]    gpio_interrupt_mask,
  input  logic [NUM_GPIO-1:0]    gpio_edge_mode,
  input  logic                   interrupt_pin,
  input  logic                   timer_enable,
  input  logic [TIMER_WIDTH-1:0] timer_duration,
  input  logic                   interrupts_enabled,
  input  logic                   interrupt_ack,
  output logic                   interrupt_requested,
  output logic [SRC_W-1:0]       interrupt_source,
  output logic [NUM_GPIO+1:0]    pending
);

  localparam int NUM_SRC = NUM_GPIO + 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    REQUEST = 1'b1
  } state_t;

  // Asynchronous inputs gathered in source order; the timer slot carries no pin.
  logic [NUM_SRC-1:0]     async_s;
  logic [NUM_SRC-1:0]     sync_r [SYNC_STAGES];
  logic [NUM_SRC-1:0]     prev_r;
  logic [NUM_SRC-1:0]     level_s;
  logic [NUM_SRC-1:0]     rise_s;
  logic [NUM_SRC-1:0]     mask_s;
  logic [NUM_SRC-1:0]     edge_s;
  logic [NUM_SRC-1:0]     clr_s;
  logic [NUM_SRC-1:0]     pend_nxt_s;
  logic [NUM_SRC-1:0]     pending_r;
  logic [TIMER_WIDTH-1:0] count_r;
  logic [TIMER_WIDTH-1:0] count_nxt_s;
  logic                   timer_fire_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   req_r;
  logic                   req_nxt_s;
  logic [SRC_W-1:0]       src_r;
  logic [SRC_W-1:0]       src_nxt_s;

  // Lowest-index set bit wins: pin, then timer, then GPIO0 upward.
  function automatic logic [SRC_W-1:0] first_set(input logic [NUM_SRC-1:0] vec);
    logic [SRC_W-1:0] idx;
    idx = {SRC_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = SRC_W'(i);
      end
    end
    return idx;
  endfunction

  assign async_s = {gpio_interrupt_pins, 1'b0, interrupt_pin};
  assign level_s = sync_r[SYNC_STAGES-1];
  assign rise_s  = level_s & ~prev_r;
  // External pin and timer are never masked and always behave as edge sources.
  assign mask_s  = {gpio_interrupt_mask, 2'b11};
  assign edge_s  = {gpio_edge_mode, 2'b11};

  // Synchroniser chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= {NUM_SRC{1'b0}};
      end
      prev_r <= {NUM_SRC{1'b0}};
    end else begin
      sync_r[0] <= async_s;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Auto-reload timer: wraps and fires on the compare edge; disabled or zero period holds 0.
  always_comb begin
    count_nxt_s  = count_r;
    timer_fire_s = 1'b0;
    if (!timer_enable || (timer_duration == {TIMER_WIDTH{1'b0}})) begin
      count_nxt_s = {TIMER_WIDTH{1'b0}};
    end else if (count_r == (timer_duration - TIMER_WIDTH'(1))) begin
      count_nxt_s  = {TIMER_WIDTH{1'b0}};
      timer_fire_s = 1'b1;
    end else begin
      count_nxt_s = count_r + TIMER_WIDTH'(1);
    end
  end

  // Timer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {TIMER_WIDTH{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  // Pending update: a set event beats a same-cycle ack; mask low clears; level bits follow the input.
  always_comb begin
    logic set_v;
    set_v      = 1'b0;
    pend_nxt_s = pending_r;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i == 1) begin
        set_v = timer_fire_s;
      end else begin
        set_v = rise_s[i];
      end
      if (!mask_s[i]) begin
        pend_nxt_s[i] = 1'b0;
      end else if (edge_s[i]) begin
        pend_nxt_s[i] = set_v | (pending_r[i] & ~clr_s[i]);
      end else begin
        pend_nxt_s[i] = level_s[i];
      end
    end
  end

  // Pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NUM_SRC{1'b0}};
    end else begin
      pending_r <= pend_nxt_s;
    end
  end

  // Arbitration: latch the winner in IDLE, hold it in REQUEST until acked.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    src_nxt_s   = src_r;
    clr_s       = {NUM_SRC{1'b0}};
    case (state_r)
      IDLE: begin
        if (interrupts_enabled && (|pending_r)) begin
          src_nxt_s   = first_set(pending_r);
          req_nxt_s   = 1'b1;
          state_nxt_s = REQUEST;
        end else begin
          req_nxt_s = 1'b0;
        end
      end
      REQUEST: begin
        if (interrupt_ack) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            clr_s[i] = (src_r == SRC_W'(i));
          end
          req_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          req_nxt_s = 1'b1;
        end
      end
      default: begin
        req_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      src_r   <= {SRC_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      req_r   <= req_nxt_s;
      src_r   <= src_nxt_s;
    end
  end

  assign interrupt_requested = req_r;
  assign interrupt_source    = src_r;
  assign pending             = pending_r;

endmodule

// File: tb/tb_interrupt_controller_n.sv
// Self-checking bench for interrupt_controller_n: directed boundary cases
// followed by randomized traffic compared against a cycle-level reference model.
module tb_interrupt_controller_n;

  localparam int NG = 8;
  localparam int TW = 32;
  localparam int SS = 2;
  localparam int NS = NG + 2;
  localparam int SW = $clog2(NG + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic [NG-1:0] gpio_interrupt_pins;
  logic [NG-1:0] gpio_interrupt_mask;
  logic [NG-1:0] gpio_edge_mode;
  logic          interrupt_pin;
  logic          timer_enable;
  logic [TW-1:0] timer_duration;
  logic          interrupts_enabled;
  logic          interrupt_ack;
  logic          interrupt_requested;
  logic [SW-1:0] interrupt_source;
  logic [NS-1:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [NS-1:0] m_pend;
  logic          m_req;
  logic [SW-1:0] m_src;
  int unsigned   m_cnt;
  logic [NS-1:0] hist [SS+2];   // hist[0] = raw inputs at the latest edge

  always #5 clk = ~clk;

  interrupt_controller_n #(
    .NUM_GPIO   (NG),
    .TIMER_WIDTH(TW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .gpio_interrupt_pins(gpio_interrupt_pins),
    .gpio_interrupt_mask(gpio_interrupt_mask),
    .gpio_edge_mode     (gpio_edge_mode),
    .interrupt_pin      (interrupt_pin),
    .timer_enable       (timer_enable),
    .timer_duration     (timer_duration),
    .interrupts_enabled (interrupts_enabled),
    .interrupt_ack      (interrupt_ack),
    .interrupt_requested(interrupt_requested),
    .interrupt_source   (interrupt_source),
    .pending            (pending)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_req  = 1'b0;
    m_src  = '0;
    m_cnt  = 0;
    for (int j = 0; j < SS + 2; j++) hist[j] = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    logic [NS-1:0] lvl, prv, rise, clr, nxt;
    logic          fire, msk, edg, st;
    int unsigned   cnt_n;
    if (rst) begin
      model_reset();
    end else begin
      // An input reaches the edge detector SS edges after it is first sampled.
      lvl  = hist[SS-1];
      prv  = hist[SS];
      rise = lvl & ~prv;
      clr  = '0;
      if (m_req && interrupt_ack) clr[m_src] = 1'b1;
      fire = 1'b0;
      if (!timer_enable || timer_duration == 0) begin
        cnt_n = 0;
      end else if (m_cnt == timer_duration - 1) begin
        cnt_n = 0;
        fire  = 1'b1;
      end else begin
        cnt_n = m_cnt + 1;
      end
      for (int i = 0; i < NS; i++) begin
        if (i < 2) begin
          msk = 1'b1;
          edg = 1'b1;
        end else begin
          msk = gpio_interrupt_mask[i-2];
          edg = gpio_edge_mode[i-2];
        end
        st = (i == 1) ? fire : rise[i];
        if (!msk)     nxt[i] = 1'b0;
        else if (edg) nxt[i] = st | (m_pend[i] & ~clr[i]);
        else          nxt[i] = lvl[i];
      end
      if (!m_req) begin
        if (interrupts_enabled && m_pend != '0) begin
          for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) m_src = SW'(i);
          m_req = 1'b1;
        end
      end else if (interrupt_ack) begin
        m_req = 1'b0;
      end
      m_pend = nxt;
      m_cnt  = cnt_n;
      for (int j = SS + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {gpio_interrupt_pins, 1'b0, interrupt_pin};
    end
  endtask

  // One clock: model follows the active edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_eq("pending", 64'(pending), 64'(m_pend));
    check_eq("requested", 64'(interrupt_requested), 64'(m_req));
    if (m_req) check_eq("source", 64'(interrupt_source), 64'(m_src));
  endtask

  initial begin
    rst                 = 1'b1;
    gpio_interrupt_pins = '0;
    gpio_interrupt_mask = '0;
    gpio_edge_mode      = '1;
    interrupt_pin       = 1'b0;
    timer_enable        = 1'b0;
    timer_duration      = '0;
    interrupts_enabled  = 1'b0;
    interrupt_ack       = 1'b0;
    model_reset();
    repeat (2) step();
    check_eq("rst_req", 64'(interrupt_requested), 64'd0);
    check_eq("rst_src", 64'(interrupt_source), 64'd0);
    check_eq("rst_pend", 64'(pending), 64'd0);
    rst = 1'b0;

    // External pin latency: pending after 3 edges, request after 4.
    interrupts_enabled = 1'b1;
    interrupt_pin      = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("ext_lat_pend", 64'(pending[0]), (k >= 3) ? 64'd1 : 64'd0);
      check_eq("ext_lat_req", 64'(interrupt_requested), (k >= 4) ? 64'd1 : 64'd0);
    end
    check_eq("ext_src", 64'(interrupt_source), 64'd0);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    check_eq("ext_ack_req", 64'(interrupt_requested), 64'd0);
    check_eq("ext_ack_pend", 64'(pending[0]), 64'd0);
    interrupt_pin = 1'b0;

    // Masked GPIO2 edge never becomes pending.
    gpio_interrupt_pins[2] = 1'b1;
    repeat (5) step();
    check_eq("mask_gpio2", 64'(pending), 64'd0);
    gpio_interrupt_pins[2] = 1'b0;

    // Timer with period 10 and requests disabled: fires on the 10th edge and holds.
    interrupts_enabled = 1'b0;
    timer_duration     = 32'd10;
    timer_enable       = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("tmr_period", 64'(pending[1]), (k >= 10) ? 64'd1 : 64'd0);
      check_eq("tmr_noreq", 64'(interrupt_requested), 64'd0);
    end
    timer_enable       = 1'b0;
    interrupts_enabled = 1'b1;
    step();
    check_eq("tmr_req", 64'(interrupt_requested), 64'd1);
    check_eq("tmr_src", 64'(interrupt_source), 64'd1);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    check_eq("tmr_ack_pend", 64'(pending[1]), 64'd0);

    // Asynchronous reset while a request is outstanding.
    interrupt_pin = 1'b1;
    repeat (4) step();
    check_eq("pre_rst_req", 64'(interrupt_requested), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_req", 64'(interrupt_requested), 64'd0);
    check_eq("async_rst_src", 64'(interrupt_source), 64'd0);
    check_eq("async_rst_pend", 64'(pending), 64'd0);
    step();
    rst           = 1'b0;
    interrupt_pin = 1'b0;

    // Randomized traffic against the reference model.
    gpio_interrupt_mask = NG'($urandom);
    gpio_edge_mode      = NG'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) interrupt_pin = ~interrupt_pin;
      gpio_interrupt_pins = gpio_interrupt_pins ^ NG'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) gpio_interrupt_mask = NG'($urandom);
      if ($urandom_range(0, 49) == 0) gpio_edge_mode = NG'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        timer_enable   = ($urandom_range(0, 3) != 0);
        timer_duration = TW'($urandom_range(0, 12));
      end
      interrupts_enabled = ($urandom_range(0, 9) != 0);
      interrupt_ack      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
